downcount_seg_driver: RTL and testbench

Downstream consumer of the 4-bit down-counter output Q.
- Samples the counter value and detects underflow wrap (0 -> F).
- Keeps a second "borrow" digit that counts down once per wrap.
- Drives a 2-digit, time-multiplexed, active-low 7-segment display showing {hi digit, counter value}.

---
 rtl/downcount_seg_driver_pkg.sv | 26 ++
 rtl/downcount_seg_driver_hex_to_seg7.sv | 32 +++
 rtl/downcount_seg_driver.sv | 69 ++++++
 tb/tb_downcount_seg_driver.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/downcount_seg_driver_pkg.sv
// Shared constants for the down-counter display driver: active-low segment
// patterns (gfedcba) and active-low digit-enable codes.
package downcount_seg_driver_pkg;

  localparam logic [6:0] SEG_0 = 7'h40;
  localparam logic [6:0] SEG_1 = 7'h79;
  localparam logic [6:0] SEG_2 = 7'h24;
  localparam logic [6:0] SEG_3 = 7'h30;
  localparam logic [6:0] SEG_4 = 7'h19;
  localparam logic [6:0] SEG_5 = 7'h12;
  localparam logic [6:0] SEG_6 = 7'h02;
  localparam logic [6:0] SEG_7 = 7'h78;
  localparam logic [6:0] SEG_8 = 7'h00;
  localparam logic [6:0] SEG_9 = 7'h10;
  localparam logic [6:0] SEG_A = 7'h08;
  localparam logic [6:0] SEG_B = 7'h03;
  localparam logic [6:0] SEG_C = 7'h46;
  localparam logic [6:0] SEG_D = 7'h21;
  localparam logic [6:0] SEG_E = 7'h06;
  localparam logic [6:0] SEG_F = 7'h0E;

  localparam logic [1:0] AN_DIG0 = 2'b10;
  localparam logic [1:0] AN_DIG1 = 2'b01;
  localparam logic [1:0] AN_OFF  = 2'b11;

endpackage

// File: rtl/downcount_seg_driver_hex_to_seg7.sv
// Combinational hex digit to active-low 7-segment pattern (gfedcba).
module hex_to_seg7
  import downcount_seg_driver_pkg::*;
(
  input  logic [3:0] digit,
  output logic [6:0] seg
);

  always_comb begin
    seg = SEG_0;
    case (digit)
      4'h0: seg = SEG_0;
      4'h1: seg = SEG_1;
      4'h2: seg = SEG_2;
      4'h3: seg = SEG_3;
      4'h4: seg = SEG_4;
      4'h5: seg = SEG_5;
      4'h6: seg = SEG_6;
      4'h7: seg = SEG_7;
      4'h8: seg = SEG_8;
      4'h9: seg = SEG_9;
      4'hA: seg = SEG_A;
      4'hB: seg = SEG_B;
      4'hC: seg = SEG_C;
      4'hD: seg = SEG_D;
      4'hE: seg = SEG_E;
      4'hF: seg = SEG_F;
      default: seg = SEG_0;
    endcase
  end

endmodule

// File: rtl/downcount_seg_driver.sv
// Watches a 4-bit down-counter, counts its 0->F wraps in a borrow digit and
// scans both digits onto a 2-digit multiplexed active-low 7-segment display.
module downcount_seg_driver
  import downcount_seg_driver_pkg::*;
#(
  parameter int         SCAN_DIV = 4,
  parameter logic [3:0] HI_INIT  = 4'h0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] q_in,
  input  logic       en,
  output logic       borrow,
  output logic [3:0] hi_digit,
  output logic [6:0] seg,
  output logic [1:0] an
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_DIV - 1);

  logic [3:0]    q_d;
  logic          prev_valid;
  logic [CW-1:0] scan_cnt;
  logic          sel;
  logic          wrap;
  logic [3:0]    shown_digit;
  logic [6:0]    seg_next;

  // prev_valid gates detection so the first sample after reset cannot look like a wrap
  assign wrap        = prev_valid & en & (q_d == 4'h0) & (q_in == 4'hF);
  assign shown_digit = sel ? hi_digit : q_d;

  hex_to_seg7 u_dec (
    .digit (shown_digit),
    .seg   (seg_next)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      q_d        <= 4'h0;
      prev_valid <= 1'b0;
      borrow     <= 1'b0;
      hi_digit   <= HI_INIT;
      scan_cnt   <= '0;
      sel        <= 1'b0;
      an         <= AN_DIG0;
      seg        <= SEG_0;
    end else begin
      q_d        <= q_in;
      prev_valid <= 1'b1;
      borrow     <= wrap;
      if (wrap)
        hi_digit <= hi_digit - 4'h1;

      if (scan_cnt == SCAN_LAST) begin
        scan_cnt <= '0;
        sel      <= ~sel;
      end else begin
        scan_cnt <= scan_cnt + CW'(1);
      end

      // an and seg load from the same sel on the same edge, so digits never ghost
      an  <= sel ? AN_DIG1 : AN_DIG0;
      seg <= seg_next;
    end
  end

endmodule

// File: tb/tb_downcount_seg_driver.sv
// Bench for downcount_seg_driver: directed and random counter sequences
// compared each cycle against a cycle-count based reference model.
module tb_downcount_seg_driver;

  localparam int         SCAN_DIV = 4;
  localparam logic [3:0] HI_INIT  = 4'h0;

  logic       clk;
  logic       reset;
  logic [3:0] q_in;
  logic       en;
  logic       borrow;
  logic [3:0] hi_digit;
  logic [6:0] seg;
  logic [1:0] an;

  int total = 0;
  int bad   = 0;

  logic [6:0] segTab [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

  // reference model state: edges since reset, last sampled value, borrow digit
  int         mEdges;
  bit         mPrev;
  logic [3:0] mLastQ;
  logic [3:0] mHi;
  logic       expBorrow;
  logic [1:0] expAn;
  logic [6:0] expSeg;
  int         modelPulses;
  int         seenPulses;

  downcount_seg_driver #(.SCAN_DIV(SCAN_DIV), .HI_INIT(HI_INIT)) dut (
    .clk      (clk),
    .reset    (reset),
    .q_in     (q_in),
    .en       (en),
    .borrow   (borrow),
    .hi_digit (hi_digit),
    .seg      (seg),
    .an       (an)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic modelReset();
    mEdges    = 0;
    mPrev     = 1'b0;
    mLastQ    = 4'h0;
    mHi       = HI_INIT;
    expBorrow = 1'b0;
    expAn     = 2'b10;
    expSeg    = 7'h40;
  endtask

  task automatic checkOutput(input string tag);
    total++;
    assert (borrow === expBorrow) else begin
      bad++;
      $error("[TB] FAIL %s borrow got=%b want=%b", tag, borrow, expBorrow);
    end
    total++;
    assert (hi_digit === mHi) else begin
      bad++;
      $error("[TB] FAIL %s hi_digit got=%h want=%h", tag, hi_digit, mHi);
    end
    total++;
    assert (an === expAn) else begin
      bad++;
      $error("[TB] FAIL %s an got=%b want=%b", tag, an, expAn);
    end
    total++;
    assert (seg === expSeg) else begin
      bad++;
      $error("[TB] FAIL %s seg got=%h want=%h", tag, seg, expSeg);
    end
  endtask

  // one clock: drive inputs, advance the model on the edge, check 1 ns later
  task automatic applyStimulus(input logic [3:0] q, input logic e, input string tag);
    bit isWrap;
    bit showHi;
    q_in = q;
    en   = e;
    @(posedge clk);
    isWrap    = mPrev && e && (mLastQ == 4'h0) && (q == 4'hF);
    showHi    = ((mEdges / SCAN_DIV) % 2) == 1;
    expBorrow = isWrap;
    expAn     = showHi ? 2'b01 : 2'b10;
    expSeg    = segTab[showHi ? mHi : mLastQ];
    if (isWrap) begin
      mHi = mHi - 4'h1;
      modelPulses++;
    end
    mLastQ = q;
    mPrev  = 1'b1;
    mEdges++;
    #1;
    if (borrow === 1'b1) seenPulses++;
    checkOutput(tag);
  endtask

  initial begin
    reset       = 1'b0;
    q_in        = 4'hF;
    en          = 1'b1;
    modelPulses = 0;
    seenPulses  = 0;
    modelReset();
    $display("[TB] start");

    #20;
    checkOutput("in_reset");
    #2 reset = 1'b1;

    for (int i = 0; i < 3; i++) applyStimulus(4'hF, 1'b1, "after_release");

    begin
      logic [3:0] seq [5] = '{4'h2, 4'h1, 4'h0, 4'hF, 4'hE};
      for (int i = 0; i < 5; i++) applyStimulus(seq[i], 1'b1, "single_wrap");
    end
    total++;
    assert (hi_digit === 4'hF) else begin
      bad++;
      $error("[TB] FAIL single_wrap_hi got=%h want=%h", hi_digit, 4'hF);
    end
    for (int i = 0; i < 8; i++) applyStimulus(4'hE, 1'b1, "show_hi");

    seenPulses  = 0;
    modelPulses = 0;
    for (int r = 0; r < 17; r++)
      for (int v = 15; v >= 0; v--) applyStimulus(4'(v), 1'b1, "countdown");
    applyStimulus(4'hF, 1'b1, "countdown_end");
    total++;
    assert (seenPulses == 17) else begin
      bad++;
      $error("[TB] FAIL pulse_count got=%0d want=%0d", seenPulses, 17);
    end
    total++;
    assert (hi_digit === 4'hE) else begin
      bad++;
      $error("[TB] FAIL countdown_hi got=%h want=%h", hi_digit, 4'hE);
    end

    applyStimulus(4'h0, 1'b1, "en_off_pre");
    applyStimulus(4'hF, 1'b0, "en_off_wrap");
    applyStimulus(4'hE, 1'b0, "en_off_post");
    applyStimulus(4'h0, 1'b1, "en_on_pre");
    applyStimulus(4'hF, 1'b1, "en_on_wrap");
    applyStimulus(4'h1, 1'b1, "one_to_f_pre");
    applyStimulus(4'hF, 1'b1, "one_to_f");
    applyStimulus(4'hF, 1'b1, "held_f");

    for (int i = 0; i < 20; i++) applyStimulus(4'h5, 1'b1, "steady5");

    for (int i = 0; i < 300; i++) begin
      logic [3:0] rq;
      logic       re;
      case ($urandom_range(0, 3))
        0:       rq = 4'h0;
        1:       rq = 4'hF;
        default: rq = 4'($urandom_range(0, 15));
      endcase
      re = ($urandom_range(0, 9) != 0);
      applyStimulus(rq, re, "random");
    end

    // steer to hi_digit == 3 while digit1 is selected, then reset between edges
    for (int i = 0; i < 40 && mHi != 4'h3; i++) begin
      applyStimulus(4'h0, 1'b1, "steer_pre");
      applyStimulus(4'hF, 1'b1, "steer_wrap");
    end
    for (int i = 0; i < 2 * SCAN_DIV && ((mEdges / SCAN_DIV) % 2) != 0; i++)
      applyStimulus(4'h7, 1'b1, "steer_sel");
    for (int i = 0; i < 2 * SCAN_DIV && ((mEdges / SCAN_DIV) % 2) != 1; i++)
      applyStimulus(4'h7, 1'b1, "steer_sel");
    applyStimulus(4'h0, 1'b1, "pre_reset");
    total++;
    assert (hi_digit === 4'h3) else begin
      bad++;
      $error("[TB] FAIL steer_hi got=%h want=%h", hi_digit, 4'h3);
    end
    #2 reset = 1'b0;
    #1;
    modelReset();
    checkOutput("async_reset");
    @(negedge clk);
    checkOutput("reset_held");
    reset = 1'b1;

    applyStimulus(4'hF, 1'b1, "post_reset_f");
    applyStimulus(4'hE, 1'b1, "post_reset_e");
    applyStimulus(4'h0, 1'b1, "post_reset_0");
    applyStimulus(4'hF, 1'b1, "post_reset_wrap");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
